// File: rtl/hc595_scan_ctrl_if.sv
// Frame channel between the scan scheduler and the 74HC595 shift/latch driver.
// A frame moves on the rising clock edge where frm_valid and frm_ready are both high; once frm_valid rises, it and frm_data stay put until that edge.
interface hc595_scan_ctrl_if;
    logic        frm_valid;
    logic [15:0] frm_data;
    logic        frm_ready;

    modport master (output frm_valid, output frm_data, input frm_ready);
    modport slave  (input frm_valid, input frm_data, output frm_ready);
endinterface

// File: rtl/hc595_scan_ctrl.sv
// Scan scheduler for an 8-digit multiplexed 7-seg display behind a 74HC595 driver.
// Optional build macro: LEAD_ZERO_BLANK_EN (blank leading-zero digits above digit 0).
module hc595_scan_ctrl #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int NUM_DIGITS     = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     disp_en,
    input  logic [31:0]              disp_data,
    input  logic [7:0]               dp_mask,
    input  logic                     upd_stb,
    hc595_scan_ctrl_if.master        frm,
    output logic [2:0]               scan_idx,
    output logic                     overrun,
    output logic [2:0]               state_dbg
);

    localparam int TICK_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [15:0]      BLANK_FRAME = {(SEG_ACTIVE_LOW ? 8'hFF : 8'h00), 8'hFF};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_LOAD      = 3'd2,
        S_SEND      = 3'd3,
        S_BLANK     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_pend_q, tick_pend_d;
    logic              overrun_q, overrun_d;
    logic [2:0]        scan_idx_q, scan_idx_d;
    logic [15:0]       frame_q, frame_d;
    logic [31:0]       shadow_img_q, shadow_img_d;
    logic [7:0]        shadow_dp_q, shadow_dp_d;
    logic [31:0]       stage_img_q, stage_img_d;
    logic [7:0]        stage_dp_q, stage_dp_d;
    logic              upd_pend_q, upd_pend_d;

    logic              tick;
    logic              copy_stage;
    logic [31:0]       img_sel;
    logic [7:0]        dp_sel;
    logic [3:0]        nib;
    logic [7:0]        seg_raw;
    logic [7:0]        seg_out;
    logic [15:0]       load_frame;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick = disp_en && (cnt_q == CNT_MAX);

    // A digit-0 load with an update pending must already show the staged image.
    assign copy_stage = (state_q == S_LOAD) && (scan_idx_q == 3'd0) && upd_pend_q;

    always_comb begin
        img_sel = copy_stage ? stage_img_q : shadow_img_q;
        dp_sel  = copy_stage ? stage_dp_q  : shadow_dp_q;
        nib     = img_sel[{scan_idx_q, 2'b00} +: 4];
        seg_raw = {dp_sel[scan_idx_q], hex7(nib)};
`ifdef LEAD_ZERO_BLANK_EN
        begin
            logic any_nz;
            any_nz = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (i < NUM_DIGITS && 3'(i) >= scan_idx_q && img_sel[i*4 +: 4] != 4'h0)
                    any_nz = 1'b1;
            end
            if (scan_idx_q != 3'd0 && !any_nz)
                seg_raw[6:0] = 7'h00;
        end
`endif
        seg_out    = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        load_frame = {seg_out, ~(8'd1 << scan_idx_q)};
    end

    // State register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (disp_en) state_d = S_WAIT_TICK;
            S_WAIT_TICK: begin
                if (tick || tick_pend_q) state_d = S_LOAD;
                else if (!disp_en)       state_d = S_BLANK;
            end
            S_LOAD:      state_d = S_SEND;
            S_SEND:      if (frm.frm_ready) state_d = disp_en ? S_WAIT_TICK : S_BLANK;
            S_BLANK:     if (frm.frm_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; frm_valid falls with the async reset of state_q
    always_comb begin
        frm.frm_valid = (state_q == S_SEND) || (state_q == S_BLANK);
        frm.frm_data  = frame_q;
        scan_idx      = scan_idx_q;
        overrun       = overrun_q;
        state_dbg     = state_q;
    end

    always_comb begin
        cnt_d        = disp_en ? ((cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1)) : '0;
        tick_pend_d  = tick_pend_q;
        overrun_d    = overrun_q;
        scan_idx_d   = scan_idx_q;
        frame_d      = frame_q;
        stage_img_d  = upd_stb ? disp_data : stage_img_q;
        stage_dp_d   = upd_stb ? dp_mask   : stage_dp_q;
        upd_pend_d   = upd_stb || (upd_pend_q && !copy_stage);
        shadow_img_d = copy_stage ? stage_img_q : shadow_img_q;
        shadow_dp_d  = copy_stage ? stage_dp_q  : shadow_dp_q;

        case (state_q)
            // Consuming a pending tick while a fresh one arrives re-arms the pending slot.
            S_WAIT_TICK: tick_pend_d = tick_pend_q && tick;
            S_LOAD, S_SEND: begin
                if (tick) begin
                    if (tick_pend_q) overrun_d   = 1'b1;
                    else             tick_pend_d = 1'b1;
                end
                if (state_q == S_SEND && frm.frm_ready)
                    scan_idx_d = (scan_idx_q == LAST_IDX) ? 3'd0 : scan_idx_q + 3'd1;
            end
            S_BLANK: begin
                if (frm.frm_ready) begin
                    scan_idx_d  = 3'd0;
                    tick_pend_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (state_q == S_LOAD)
            frame_d = load_frame;
        else if (state_d == S_BLANK && state_q != S_BLANK)
            frame_d = BLANK_FRAME;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            tick_pend_q  <= 1'b0;
            overrun_q    <= 1'b0;
            scan_idx_q   <= 3'd0;
            frame_q      <= 16'hFFFF;
            shadow_img_q <= 32'h0;
            shadow_dp_q  <= 8'h0;
            stage_img_q  <= 32'h0;
            stage_dp_q   <= 8'h0;
            upd_pend_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tick_pend_q  <= tick_pend_d;
            overrun_q    <= overrun_d;
            scan_idx_q   <= scan_idx_d;
            frame_q      <= frame_d;
            shadow_img_q <= shadow_img_d;
            shadow_dp_q  <= shadow_dp_d;
            stage_img_q  <= stage_img_d;
            stage_dp_q   <= stage_dp_d;
            upd_pend_q   <= upd_pend_d;
        end
    end

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Directed bench for hc595_scan_ctrl at TICK_DIV=50; expectations follow LEAD_ZERO_BLANK_EN when defined.
module tb_hc595_scan_ctrl;

    localparam int W = 19;  // {scan_idx[2:0], seg[7:0], dig_sel[7:0]}

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [7:0] ZS  = 8'hFF;  // leading zero digit
    localparam logic [7:0] DP2 = 8'h7F;  // blanked zero with dp on
`else
    localparam logic [7:0] ZS  = 8'hC0;
    localparam logic [7:0] DP2 = 8'h40;
`endif

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        disp_en;
    logic [31:0] disp_data;
    logic [7:0]  dp_mask;
    logic        upd_stb;
    logic [2:0]  scan_idx;
    logic        overrun;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    hc595_scan_ctrl_if frm_if();

    hc595_scan_ctrl #(
        .CLK_FREQ_HZ(50_000),
        .SCAN_HZ    (1000)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .disp_en  (disp_en),
        .disp_data(disp_data),
        .dp_mask  (dp_mask),
        .upd_stb  (upd_stb),
        .frm      (frm_if),
        .scan_idx (scan_idx),
        .overrun  (overrun),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] idx, input logic [7:0] seg, input logic [7:0] dig);
        exp_q.push_back({idx, seg, dig});
    endtask

    function automatic logic [7:0] dsel(input int i);
        logic [7:0] one;
        one = 8'd1 << i;
        return ~one;
    endfunction

    // Driver: one-cycle update strobe, entered and left at a negedge
    task automatic strobe(input logic [31:0] data, input logic [7:0] dp);
        disp_data = data;
        dp_mask   = dp;
        upd_stb   = 1'b1;
        @(negedge sys_clk);
        upd_stb   = 1'b0;
    endtask

    // Scoreboard: waits (bounded) for frm_valid, then compares against the queue head
    task automatic wait_frame(input string tag, input int exp_lat, input bit chk_idx);
        int n;
        logic [W-1:0] e;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!frm_if.frm_valid && n < 400);
        check({tag, "_valid"}, frm_if.frm_valid, 1);
        if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_data"}, frm_if.frm_data, e[15:0]);
        if (chk_idx) check({tag, "_idx"}, scan_idx, e[18:16]);
    endtask

    initial begin
        int cnt;
        logic [15:0] held;

        rst = 1'b1; disp_en = 1'b0; disp_data = '0; dp_mask = '0; upd_stb = 1'b0;
        frm_if.frm_ready = 1'b1;

        // Reset values
        repeat (20) @(negedge sys_clk);
        check("rst_valid", frm_if.frm_valid, 0);
        check("rst_data", frm_if.frm_data, 16'hFFFF);
        check("rst_idx", scan_idx, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        cnt = 0;
        repeat (200) begin
            @(negedge sys_clk);
            if (frm_if.frm_valid) cnt++;
        end
        check("disabled_no_frames", cnt, 0);
        check("disabled_idle", state_dbg, 0);

        // Normal scan of 0x12, wrap back to digit 0
        strobe(32'h0000_0012, 8'h00);
        disp_en = 1'b1;
        push(3'd0, 8'hA4, 8'hFE);
        wait_frame("t2_d0", 51, 1);
        for (int i = 1; i < 8; i++) begin
            push(3'(i), (i == 1) ? 8'hF9 : ZS, dsel(i));
            wait_frame($sformatf("t2_d%0d", i), 50, 1);
        end
        push(3'd0, 8'hA4, 8'hFE);
        wait_frame("t2_wrap", 50, 1);

        // Back-pressure: frame frozen, one pending tick, then overrun
        @(negedge sys_clk);
        frm_if.frm_ready = 1'b0;
        push(3'd1, 8'hF9, 8'hFD);
        wait_frame("t3_d1", 49, 1);
        held = frm_if.frm_data;
        cnt = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge sys_clk);
            if (!frm_if.frm_valid || frm_if.frm_data !== held || scan_idx !== 3'd1) cnt++;
            if (i == 60) check("t3_overrun_early", overrun, 0);
        end
        check("t3_stable", cnt, 0);
        check("t3_overrun", overrun, 1);
        frm_if.frm_ready = 1'b1;
        push(3'd2, ZS, 8'hFB);
        wait_frame("t3_pend", 3, 1);

        // Tear-free update requested mid-scan
        @(negedge sys_clk);
        check("t4_idx", scan_idx, 3);
        strobe(32'h8888_8888, 8'h00);
        push(3'd3, ZS, 8'hF7);
        wait_frame("t4_d3", -1, 1);
        for (int i = 4; i < 8; i++) begin
            push(3'(i), ZS, dsel(i));
            wait_frame($sformatf("t4_d%0d", i), 50, 1);
        end
        push(3'd0, 8'h80, 8'hFE);
        wait_frame("t4_new0", 50, 1);
        push(3'd1, 8'h80, 8'hFD);
        wait_frame("t4_new1", 50, 1);

        // Disable while a frame is held, then the blank frame
        @(negedge sys_clk);
        frm_if.frm_ready = 1'b0;
        push(3'd2, 8'h80, 8'hFB);
        wait_frame("t5_d2", 49, 1);
        disp_en = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (!frm_if.frm_valid || frm_if.frm_data !== 16'h80FB) cnt++;
        end
        check("t5_held", cnt, 0);
        frm_if.frm_ready = 1'b1;
        push(3'd0, 8'hFF, 8'hFF);
        wait_frame("t5_blank", 1, 0);
        @(negedge sys_clk);
        check("t5_valid_low", frm_if.frm_valid, 0);
        check("t5_idx0", scan_idx, 0);
        check("t5_idle", state_dbg, 0);
        cnt = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (frm_if.frm_valid) cnt++;
        end
        check("t5_no_frames", cnt, 0);

        // Decimal point on digit 2, then async reset mid-frame
        strobe(32'h0000_0012, 8'h04);
        disp_en = 1'b1;
        push(3'd0, 8'hA4, 8'hFE);
        wait_frame("t6_d0", 51, 1);
        push(3'd1, 8'hF9, 8'hFD);
        wait_frame("t6_d1", 50, 1);
        push(3'd2, DP2, 8'hFB);
        wait_frame("t6_d2", 50, 1);
        @(negedge sys_clk);
        frm_if.frm_ready = 1'b0;
        push(3'd3, ZS, 8'hF7);
        wait_frame("t6_d3", 49, 1);
        check("t6_sticky", overrun, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", frm_if.frm_valid, 0);
        check("arst_data", frm_if.frm_data, 16'hFFFF);
        check("arst_idx", scan_idx, 0);
        check("arst_overrun", overrun, 0);
        check("arst_idle", state_dbg, 0);
        check("sb_empty", exp_q.size(), 0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
